// File: rtl/irq_controller_pkg.sv
// Shared types for the interrupt controller: config register map and FSM states.
package irq_controller_pkg;

  // Config register addresses on cfg_addr
  typedef enum logic [1:0] {
    CFG_MASK   = 2'd0,
    CFG_MODE   = 2'd1,
    CFG_PEND   = 2'd2,
    CFG_ACTIVE = 2'd3
  } cfg_addr_e;

  // Request FSM: either idle or holding a request until the control unit acks
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/irq_controller_if.sv
// Bus between the interrupt controller and the control unit: config access
// plus the request / acknowledge / end-of-interrupt handshake.
interface irq_controller_if #(
  parameter int NUM_IRQ = 8,
  parameter int ADDR_W  = 32
) ();
  localparam int ID_W = $clog2(NUM_IRQ);

  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] cfg_rdata;
  logic               int_req;
  logic [ID_W-1:0]    int_id;
  logic [ADDR_W-1:0]  int_vector;
  logic               int_ack;
  logic               eoi;

  // Control unit side
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, eoi,
    input  cfg_rdata, int_req, int_id, int_vector
  );

  // Interrupt controller side
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, eoi,
    output cfg_rdata, int_req, int_id, int_vector
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Find-first-set priority encoder: lowest set bit wins (index 0 = highest priority).
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IDX_W = $clog2(N);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/irq_controller.sv
// Multi-source interrupt controller: synchronises sources, latches pending,
// applies mask/mode/fixed priority with nesting, and presents one held
// request plus vector to the control unit until it is acknowledged.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int                NUM_IRQ    = 8,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 'h100,
  parameter int                VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_controller_if.slave    bus
);
  localparam int ID_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d, mode_q, mode_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, act_q, act_d;
  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ADDR_W-1:0]  vec_q, vec_d;

  logic [NUM_IRQ-1:0] rise, elig, w1c, mode_chg, rdata;
  logic               cand_valid, act_valid, preempt_ok, ack_take;
  logic [ID_W-1:0]    cand_idx, act_idx;
  cfg_addr_e          addr;

  // Vector for a source id; wraps modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] vec_of(input logic [ID_W-1:0] id);
    return VEC_BASE + ADDR_W'(id) * ADDR_W'(VEC_STRIDE);
  endfunction

  assign addr     = cfg_addr_e'(bus.cfg_addr);
  assign rise     = sync2_q & ~dly_q;
  assign elig     = pend_q & mask_q & ~act_q;
  assign ack_take = bus.int_ack && (state_q == ST_REQ);
  assign w1c      = (bus.cfg_we && addr == CFG_PEND) ? bus.cfg_wdata : '0;
  assign mode_chg = (bus.cfg_we && addr == CFG_MODE) ? (bus.cfg_wdata ^ mode_q) : '0;

  irq_prio_enc #(.N(NUM_IRQ)) u_cand_enc (
    .vec   (elig),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  irq_prio_enc #(.N(NUM_IRQ)) u_act_enc (
    .vec   (act_q),
    .valid (act_valid),
    .idx   (act_idx)
  );

  // A candidate may only interrupt if it outranks everything already in service
  assign preempt_ok = !act_valid || (cand_idx < act_idx);

  // Two-flop synchroniser followed by one delay flop for edge detection
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  // MASK and MODE are plain read/write registers
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (bus.cfg_we) begin
      case (addr)
        CFG_MASK: mask_d = bus.cfg_wdata;
        CFG_MODE: mode_d = bus.cfg_wdata;
        default:  ;
      endcase
    end
  end

  // Pending: level bits track the synced input, edge bits latch rises (set beats clear)
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!mode_q[i]) begin
        pend_d[i] = sync2_q[i];
      end else if (rise[i]) begin
        pend_d[i] = 1'b1;
      end else if (w1c[i] || (ack_take && id_q == ID_W'(i))) begin
        pend_d[i] = 1'b0;
      end
      if (mode_chg[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // In-service set: eoi retires the highest-priority active source, then ack adds the new one
  always_comb begin
    act_d = act_q;
    if (bus.eoi && act_valid) begin
      act_d[act_idx] = 1'b0;
    end
    if (ack_take) begin
      act_d[id_q] = 1'b1;
    end
  end

  // Request FSM: latch id/vector on entry to REQ and hold them until ack
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid && preempt_ok) begin
          state_d = ST_REQ;
          id_d    = cand_idx;
          vec_d   = vec_of(cand_idx);
        end
      end
      ST_REQ: begin
        if (bus.int_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational config read mux
  always_comb begin
    rdata = '0;
    case (addr)
      CFG_MASK:   rdata = mask_q;
      CFG_MODE:   rdata = mode_q;
      CFG_PEND:   rdata = pend_q;
      CFG_ACTIVE: rdata = act_q;
      default:    rdata = '0;
    endcase
  end

  assign bus.cfg_rdata  = rdata;
  assign bus.int_req    = (state_q == ST_REQ);
  assign bus.int_id     = id_q;
  assign bus.int_vector = vec_q;

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      state_q <= ST_IDLE;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      state_q <= state_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: expected request ids are queued when
// sources are driven and compared when the controller raises int_req.
module tb_irq_controller;
  import irq_controller_pkg::*;

  localparam int          NUM_IRQ    = 8;
  localparam int          ADDR_W     = 32;
  localparam logic [31:0] VEC_BASE   = 32'h100;
  localparam int          VEC_STRIDE = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NUM_IRQ-1:0] irq_in = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int lat;

  always #5 clk = ~clk;

  irq_controller_if #(.NUM_IRQ(NUM_IRQ), .ADDR_W(ADDR_W)) bus ();

  irq_controller #(
    .NUM_IRQ    (NUM_IRQ),
    .ADDR_W     (ADDR_W),
    .VEC_BASE   (VEC_BASE),
    .VEC_STRIDE (VEC_STRIDE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .bus    (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.cfg_addr = a;
    #1;
    check_val(tag, 64'(bus.cfg_rdata), 64'(exp));
  endtask

  task automatic pulse(input logic do_ack, input logic do_eoi);
    bus.int_ack = do_ack;
    bus.eoi     = do_eoi;
    tick();
    bus.int_ack = 1'b0;
    bus.eoi     = 1'b0;
  endtask

  // One-cycle source pulse, then drop it
  task automatic irq_pulse(input logic [7:0] v);
    irq_in = v;
    tick();
    irq_in = '0;
  endtask

  // Wait (bounded) for int_req, then pop the scoreboard and compare id/vector
  task automatic wait_req(input string tag, output int n);
    int id;
    n = 0;
    while (!bus.int_req && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_req"}, 64'(bus.int_req), 64'd1);
    if (bus.int_req) begin
      if (exp_q.size() == 0) begin
        check_val({tag, "_unexpected"}, 64'(exp_q.size()), 64'd1);
      end else begin
        id = exp_q.pop_front();
        check_val({tag, "_id"}, 64'(bus.int_id), 64'(id));
        check_val({tag, "_vec"}, 64'(bus.int_vector), 64'(VEC_BASE + 32'(id) * 32'(VEC_STRIDE)));
      end
    end
  endtask

  task automatic no_req(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (bus.int_req) seen = 1'b1;
    end
    check_val(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic held;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.int_ack   = 1'b0;
    bus.eoi       = 1'b0;

    // Reset with all sources high
    rst    = 1'b0;
    irq_in = 8'hFF;
    tick();
    tick();
    check_val("rst_req", 64'(bus.int_req), 64'd0);
    check_val("rst_id", 64'(bus.int_id), 64'd0);
    check_val("rst_vec", 64'(bus.int_vector), 64'h100);
    rd_chk("rst_mask", 2'd0, 8'h00);
    rd_chk("rst_mode", 2'd1, 8'h00);
    rd_chk("rst_pend", 2'd2, 8'h00);
    rd_chk("rst_act", 2'd3, 8'h00);
    irq_in = '0;
    rst    = 1'b1;
    repeat (4) tick();

    // Single edge source, latency, ack and eoi
    cfg_wr(2'd0, 8'h08);
    cfg_wr(2'd1, 8'h08);
    exp_q.push_back(3);
    irq_pulse(8'h08);
    wait_req("t2", lat);
    check_val("t2_lat", 64'(lat), 64'd3);
    pulse(1'b1, 1'b0);
    check_val("t2_req_drop", 64'(bus.int_req), 64'd0);
    rd_chk("t2_act", 2'd3, 8'h08);
    rd_chk("t2_pend", 2'd2, 8'h00);
    cfg_wr(2'd3, 8'hFF);
    rd_chk("t2_act_ro", 2'd3, 8'h08);
    pulse(1'b0, 1'b1);
    rd_chk("t2_act_eoi", 2'd3, 8'h00);

    // Priority between two simultaneous edge sources
    cfg_wr(2'd0, 8'hFF);
    cfg_wr(2'd1, 8'hFF);
    exp_q.push_back(2);
    irq_pulse(8'h24);
    wait_req("t3a", lat);
    pulse(1'b1, 1'b0);
    rd_chk("t3_act", 2'd3, 8'h04);
    rd_chk("t3_pend", 2'd2, 8'h20);
    no_req("t3_no_lower", 6);
    exp_q.push_back(5);
    pulse(1'b0, 1'b1);
    wait_req("t3b", lat);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    rd_chk("t3_act_end", 2'd3, 8'h00);

    // Nesting: higher-priority source preempts an active one
    exp_q.push_back(4);
    irq_pulse(8'h10);
    wait_req("t4a", lat);
    pulse(1'b1, 1'b0);
    rd_chk("t4_act1", 2'd3, 8'h10);
    exp_q.push_back(1);
    irq_pulse(8'h02);
    wait_req("t4b", lat);
    pulse(1'b1, 1'b0);
    rd_chk("t4_act2", 2'd3, 8'h12);
    pulse(1'b0, 1'b1);
    rd_chk("t4_act3", 2'd3, 8'h10);
    pulse(1'b0, 1'b1);
    rd_chk("t4_act4", 2'd3, 8'h00);

    // Request held even after the source drops and is masked
    cfg_wr(2'd1, 8'hBF);
    irq_in = 8'h40;
    exp_q.push_back(6);
    wait_req("t5", lat);
    irq_in = '0;
    cfg_wr(2'd0, 8'h00);
    held = 1'b1;
    repeat (5) begin
      tick();
      if (!bus.int_req || bus.int_id != 3'd6) held = 1'b0;
    end
    check_val("t5_held", 64'(held), 64'd1);
    pulse(1'b1, 1'b0);
    check_val("t5_req_drop", 64'(bus.int_req), 64'd0);
    rd_chk("t5_act", 2'd3, 8'h40);
    cfg_wr(2'd0, 8'hFF);
    pulse(1'b0, 1'b1);
    rd_chk("t5_act_eoi", 2'd3, 8'h00);
    no_req("t5_no_req", 6);

    // eoi and ack in the same cycle
    cfg_wr(2'd1, 8'hFF);
    exp_q.push_back(4);
    irq_pulse(8'h10);
    wait_req("t6a", lat);
    pulse(1'b1, 1'b0);
    exp_q.push_back(1);
    irq_pulse(8'h02);
    wait_req("t6b", lat);
    pulse(1'b1, 1'b1);
    rd_chk("t6_ack_eoi", 2'd3, 8'h02);
    pulse(1'b0, 1'b1);
    rd_chk("t6_act_clr", 2'd3, 8'h00);

    // eoi with nothing in service
    pulse(1'b0, 1'b1);
    rd_chk("t6_eoi_idle", 2'd3, 8'h00);
    no_req("t6_eoi_idle_req", 4);

    // Edge set and W1C on the same cycle: set wins; plain W1C clears
    cfg_wr(2'd0, 8'h7F);
    irq_pulse(8'h80);
    tick();
    cfg_wr(2'd2, 8'h80);
    rd_chk("t6_set_wins", 2'd2, 8'h80);
    cfg_wr(2'd2, 8'h80);
    rd_chk("t6_w1c", 2'd2, 8'h00);

    // Level source still high after eoi re-requests
    cfg_wr(2'd0, 8'hFF);
    cfg_wr(2'd1, 8'hBF);
    irq_in = 8'h40;
    exp_q.push_back(6);
    wait_req("t6c", lat);
    pulse(1'b1, 1'b0);
    exp_q.push_back(6);
    pulse(1'b0, 1'b1);
    wait_req("t6_rereq", lat);
    pulse(1'b1, 1'b0);
    irq_in = '0;
    repeat (5) tick();
    pulse(1'b0, 1'b1);
    rd_chk("t6_lvl_act", 2'd3, 8'h00);
    no_req("t6_lvl_quiet", 5);

    // Reset while a request is outstanding
    irq_in = 8'h40;
    exp_q.push_back(6);
    wait_req("t6d", lat);
    rst = 1'b0;
    tick();
    check_val("t6_rst_req", 64'(bus.int_req), 64'd0);
    check_val("t6_rst_id", 64'(bus.int_id), 64'd0);
    check_val("t6_rst_vec", 64'(bus.int_vector), 64'h100);
    rd_chk("t6_rst_mask", 2'd0, 8'h00);
    rd_chk("t6_rst_mode", 2'd1, 8'h00);
    irq_in = '0;
    rst    = 1'b1;
    tick();

    check_val("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
